ysyx_23060201_dmem_resp: RTL and testbench

- Data-memory responder for the `ysyx_23060201` core: the memory-side end of the store/load interface driven by the execute stage.
- Accepts one request at a time over a valid/ready request channel. A request is a read, or a byte-masked write with lane-relative mask and data.
- Performs the access on an internal word array after a programmable latency.
- Returns completion on a valid/ready response channel.

---
 rtl/ysyx_23060201_dmem_resp.sv | 99 +++++++++
 tb/tb_ysyx_23060201_dmem_resp.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_dmem_resp.sv
// ysyx_23060201_dmem_resp: single-outstanding data-memory responder with programmable latency.
// Optional address range checking is enabled by YSYX_23060201_DMEM_RANGE_CHECK_EN.
module ysyx_23060201_dmem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic wen;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] wmask;
    logic err;
    logic [31:0] mem [DEPTH_WORDS];
    logic accept, exec, in_range, a_wen;
    logic [31:0] a_addr, a_wdata, off, edata;
    logic [3:0] a_wmask, emask;
    logic [1:0] o;
    logic [AW-1:0] idx;
    assign accept = req_valid && req_ready;
    assign exec = (state_nx == RESP) && (state != RESP);
    // With zero latency the access happens on the accept edge, before the fields are latched.
    assign a_wen = (state == IDLE) ? req_wen : wen;
    assign a_addr = (state == IDLE) ? req_addr : addr;
    assign a_wdata = (state == IDLE) ? req_wdata : wdata;
    assign a_wmask = (state == IDLE) ? req_wmask : wmask;
    assign off = a_addr - BASE_ADDR;
    assign o = off[1:0];
    assign idx = off[AW+1:2];
    assign emask = a_wmask << o;
    assign edata = a_wdata << {o, 3'b000};
`ifdef YSYX_23060201_DMEM_RANGE_CHECK_EN
    assign in_range = off < 32'(4 * DEPTH_WORDS);
`else
    logic unused_hi;
    assign in_range = 1'b1;
    assign unused_hi = ^off[31:AW+2];
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE) ? (accept ? ((LATENCY == 0) ? RESP : WAIT) : IDLE)
                 : (state == WAIT) ? ((cnt == 4'd0) ? RESP : WAIT)
                 : (resp_ready ? IDLE : RESP);
    end
    always_comb begin
        req_ready = (state == IDLE) && !rst;
        resp_valid = (state == RESP);
        resp_rdata = rdata;
        resp_err = err;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            wen <= 1'b0;
            addr <= '0;
            wdata <= '0;
            wmask <= '0;
            rdata <= '0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= 4'(LATENCY - 1);
                wen <= req_wen;
                addr <= req_addr;
                wdata <= req_wdata;
                wmask <= req_wmask;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (exec) begin
                rdata <= (!a_wen && in_range) ? (mem[idx] >> {o, 3'b000}) : 32'd0;
                err <= !in_range;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (exec && a_wen && in_range && !rst)
            for (int i = 0; i < 4; i++)
                if (emask[i]) mem[idx][8*i +: 8] <= edata[8*i +: 8];
    end
endmodule

// File: tb/tb_ysyx_23060201_dmem_resp.sv
// tb_ysyx_23060201_dmem_resp: directed-vector bench for the data-memory responder.
module tb_ysyx_23060201_dmem_resp;
    localparam int LAT = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_wen = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0] req_wmask = '0;
    logic resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_rdata;
    int n_chk = 0, n_pass = 0;
    logic [31:0] rd;
    logic e;
    int n;

    ysyx_23060201_dmem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1; req_wen = w; req_addr = a; req_wdata = d; req_wmask = m;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = ~w; req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'hF;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!resp_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                        input int hold, output logic [31:0] rdo, output logic eo);
        int cyc;
        issue(w, a, d, m);
        wait_valid(cyc);
        chk("latency", cyc, LAT + 1);
        rdo = resp_rdata; eo = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, rdo);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_req_ready", req_ready, 1);
        chk("post_resp_valid", resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        @(negedge clk) rst = 1'b0;
        #1 chk("idle_req_ready", req_ready, 1);

        xact(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, e);
        chk("wr_rdata_zero", rd, 0);
        xact(0, 32'h8000_0010, 0, 0, 0, rd, e);
        chk("rd_word", rd, 32'hDEAD_BEEF);
        chk("rd_word_err", e, 0);

        xact(1, 32'h8000_0012, 32'h0000_00AA, 4'b0001, 0, rd, e);
        xact(0, 32'h8000_0010, 0, 0, 0, rd, e);
        chk("rd_after_byte", rd, 32'hDEAA_BEEF);
        xact(0, 32'h8000_0012, 0, 0, 0, rd, e);
        chk("rd_off2", rd, 32'h0000_DEAA);

        xact(1, 32'h8000_0013, 32'h0000_1234, 4'b0011, 0, rd, e);
        xact(0, 32'h8000_0010, 0, 0, 0, rd, e);
        chk("rd_after_half_lane3", rd, 32'h34AA_BEEF);
        xact(0, 32'h8000_0011, 0, 0, 5, rd, e);
        chk("rd_off1_hold", rd, 32'h0034_AABE);
        xact(0, 32'h8000_0013, 0, 0, 0, rd, e);
        chk("rd_off3", rd, 32'h0000_0034);

        xact(1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0, rd, e);
        xact(0, 32'h8000_0010, 0, 0, 0, rd, e);
        chk("mask0_no_change", rd, 32'h34AA_BEEF);

        xact(1, 32'h8000_0020, 32'h1111_2222, 4'hF, 0, rd, e);
        issue(1, 32'h8000_0020, 32'h5555_5555, 4'hF);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("abort_wait_req_ready", req_ready, 0);
        chk("abort_wait_resp_valid", resp_valid, 0);
        @(posedge clk); @(negedge clk) rst = 1'b0;
        xact(0, 32'h8000_0020, 0, 0, 0, rd, e);
        chk("aborted_write_dropped", rd, 32'h1111_2222);

        issue(1, 32'h8000_0024, 32'h0000_0077, 4'hF);
        wait_valid(n);
        chk("pre_abort_valid", resp_valid, 1);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_resp_req_ready", req_ready, 0);
        @(posedge clk); @(negedge clk) rst = 1'b0;
        xact(0, 32'h8000_0024, 0, 0, 0, rd, e);
        chk("executed_write_kept", rd, 32'h0000_0077);

`ifdef YSYX_23060201_DMEM_RANGE_CHECK_EN
        xact(0, 32'h7FFF_FFFC, 0, 0, 0, rd, e);
        chk("oor_err", e, 1);
        chk("oor_rdata", rd, 0);
        xact(1, 32'h8000_1010, 32'h0BAD_0BAD, 4'hF, 0, rd, e);
        chk("oor_wr_err", e, 1);
        xact(0, 32'h8000_0010, 0, 0, 0, rd, e);
        chk("oor_wr_no_change", rd, 32'h34AA_BEEF);
`else
        xact(0, 32'h8000_1010, 0, 0, 0, rd, e);
        chk("alias_rdata", rd, 32'h34AA_BEEF);
        chk("alias_err", e, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
